apb_wait_regs: RTL and testbench

APB3 completer (responder) holding a bank of 32-bit registers, with a programmable number of wait states inserted through PREADY and error signalling through PSLVERR. It sits on the shared APB bus opposite the existing APB requester and lets the bench exercise requester wait-state and error handling, which a zero-wait slave never triggers.

---
 rtl/apb_wait_regs.sv | 139 +++++++++++++
 tb/tb_apb_wait_regs.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_wait_regs.sv
// APB3 completer with a bank of 32-bit registers, programmable wait states and decode errors.
// Define APB_WAIT_REGS_ERR_EN to drive PSLVERR; otherwise it is tied low and bad accesses are silently absorbed.
module apb_wait_regs #(
    parameter int                 ADDR_W      = 8,
    parameter int                 DATA_W      = 32,
    parameter int                 NREGS       = 16,
    parameter int                 WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0]  ID_VALUE    = 32'hA9B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    // state  | meaning
    // IDLE   | no transfer in flight, outputs held at 0
    // ACCESS | request latched, counting wait states or presenting the response

`ifdef APB_WAIT_REGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_pready;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_pslverr;
    logic [DATA_W-1:0]   r_regs [1:NREGS-1];

    logic [ADDR_W-1:0]   w_addr;
    logic                w_write;
    logic [IDX_W-1:0]    w_idx;
    logic                w_bad;
    logic [DATA_W-1:0]   w_rd_reg;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_err;

    // With zero wait states the response is formed on the setup edge, so decode the live bus there.
    assign w_addr  = (r_state == S_IDLE) ? PADDR  : r_addr;
    assign w_write = (r_state == S_IDLE) ? PWRITE : r_write;
    assign w_idx   = w_addr[ADDR_W-1:2];
    assign w_bad   = (w_addr[1:0] != 2'b00)
                   | ({1'b0, w_idx} >= (IDX_W+1)'(NREGS))
                   | (w_write & (w_idx == '0));

    always_comb begin
        w_rd_reg = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (w_idx == IDX_W'(i)) w_rd_reg = r_regs[i];
        end
    end

    assign w_rdata = (w_write | w_bad) ? '0 : ((w_idx == '0) ? ID_VALUE : w_rd_reg);
    assign w_err   = ERR_EN & w_bad;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                    if (PSEL && !PENABLE) begin
                        r_state <= S_ACCESS;
                        r_addr  <= PADDR;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            r_pready  <= 1'b1;
                            r_prdata  <= w_rdata;
                            r_pslverr <= w_err;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!PSEL) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_pready  <= 1'b0;
                        r_prdata  <= '0;
                        r_pslverr <= 1'b0;
                    end else if (PENABLE) begin
                        if (!r_pready) begin
                            r_cnt <= r_cnt - 4'd1;
                            if (r_cnt == 4'd1) begin
                                r_pready  <= 1'b1;
                                r_prdata  <= w_rdata;
                                r_pslverr <= w_err;
                            end
                        end else begin
                            if (r_write && !w_bad) begin
                                for (int i = 1; i < NREGS; i++) begin
                                    if (w_idx == IDX_W'(i)) r_regs[i] <= r_wdata;
                                end
                            end
                            r_state   <= S_IDLE;
                            r_pready  <= 1'b0;
                            r_prdata  <= '0;
                            r_pslverr <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign PREADY  = r_pready;
    assign PRDATA  = r_prdata;
    assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_wait_regs.sv
// Bench for apb_wait_regs: two instances (2 and 0 wait states) on a shared, target-gated bus,
// directed vector table, hand sequences for abort/reset corners, and randomized traffic vs. a model.
module tb_apb_wait_regs;

`ifdef APB_WAIT_REGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        clk;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    int          tgt;
    logic        both;
    logic        psel0, psel1;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [31:0] cur_prdata;
    logic        cur_pready, cur_pslverr;

    assign psel0       = psel & (both | (tgt == 0));
    assign psel1       = psel & (both | (tgt == 1));
    assign cur_prdata  = (tgt == 1) ? prdata1  : prdata0;
    assign cur_pready  = (tgt == 1) ? pready1  : pready0;
    assign cur_pslverr = (tgt == 1) ? pslverr1 : pslverr0;

    apb_wait_regs #(.WAIT_CYCLES(2)) u_dut_w2 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

    apb_wait_regs #(.WAIT_CYCLES(0)) u_dut_w0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel1), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain register array per instance, rules applied directly from the address map.
    logic [31:0] mregs [2][16];

    task automatic model_reset();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 16; i++) mregs[t][i] = 32'h0;
    endtask

    function automatic logic [32:0] model_xfer(input int t, input logic [7:0] a, input logic w,
                                               input logic [31:0] wd);
        int idx;
        bit bad;
        logic [31:0] rd;
        idx = int'(a) / 4;
        bad = (int'(a) % 4 != 0) || (idx >= 16) || (w && idx == 0);
        rd  = 32'h0;
        if (!w && !bad) rd = (idx == 0) ? ID : mregs[t][idx];
        if (w && !bad) mregs[t][idx] = wd;
        return {bad & ERR_EN, rd};
    endfunction

    // One full APB transfer; acyc = access cycle in which PREADY was seen (0 = timeout).
    task automatic xfer(input int t, input logic [7:0] a, input logic w, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int acyc);
        tgt = t; psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr = 8'($urandom);
        pwdata = $urandom;
        acyc = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cur_pready === 1'b1) begin
                acyc = k; rd = cur_prdata; er = cur_pslverr;
                break;
            end
            @(posedge clk); #1;
        end
        if (acyc == 0) begin
            chk("xfer_timeout", 32'(acyc), 32'd1);
            psel = 1'b0; penable = 1'b0;
        end else begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ac;
        int          seen;
        logic [32:0] exp;
        int          t;
        logic [7:0]  a;
        logic        w;
        logic [31:0] wd;

        tbl[0]  = '{8'h0C, 1'b0, 32'h0,         32'h0,         1'b0};
        tbl[1]  = '{8'h0C, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[2]  = '{8'h0C, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{8'h00, 1'b1, 32'h1111_1111, 32'h0,         ERR_EN};
        tbl[4]  = '{8'h00, 1'b0, 32'h0,         ID,            1'b0};
        tbl[5]  = '{8'h40, 1'b0, 32'h0,         32'h0,         ERR_EN};
        tbl[6]  = '{8'h06, 1'b1, 32'h5555_5555, 32'h0,         ERR_EN};
        tbl[7]  = '{8'h04, 1'b0, 32'h0,         32'h0,         1'b0};
        tbl[8]  = '{8'h06, 1'b0, 32'h0,         32'h0,         ERR_EN};
        tbl[9]  = '{8'h3C, 1'b1, 32'hCAFE_F00D, 32'h0,         1'b0};
        tbl[10] = '{8'h3C, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0};

        tgt = 0; both = 1'b1; rst_n = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pready_w2",  32'(pready0),  32'h0);
        chk("rst_pslverr_w2", 32'(pslverr0), 32'h0);
        chk("rst_prdata_w2",  prdata0,       32'h0);
        chk("rst_pready_w0",  32'(pready1),  32'h0);
        chk("rst_pslverr_w0", 32'(pslverr1), 32'h0);
        chk("rst_prdata_w0",  prdata1,       32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; psel = 1'b0; both = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            exp = model_xfer(0, tbl[i].addr, tbl[i].wr, tbl[i].wdata);
            xfer(0, tbl[i].addr, tbl[i].wr, tbl[i].wdata, rd, er, ac);
            chk($sformatf("tbl%0d_ready_cycle", i), 32'(ac), 32'd3);
            chk($sformatf("tbl%0d_pslverr", i), 32'(er), 32'(tbl[i].exp_err));
            if (!tbl[i].wr) chk($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
        end

        @(negedge clk);
        chk("ready_single_pulse", 32'(pready0), 32'h0);
        @(posedge clk); #1;

        // Zero-wait instance, back-to-back reads with no idle cycle between them.
        xfer(1, 8'h00, 1'b0, 32'h0, rd, er, ac);
        chk("w0_id_ready_cycle", 32'(ac), 32'd1);
        chk("w0_id_prdata", rd, ID);
        chk("w0_id_pslverr", 32'(er), 32'h0);
        xfer(1, 8'h04, 1'b0, 32'h0, rd, er, ac);
        chk("w0_b2b_ready_cycle", 32'(ac), 32'd1);
        chk("w0_b2b_prdata", rd, 32'h0);
        @(posedge clk); #1;

        // Abort: PSEL drops during access cycle 1 of a write.
        tgt = 0; psel = 1'b1; penable = 1'b0; paddr = 8'h08; pwrite = 1'b1; pwdata = 32'h1234_5678;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("abort_ready_c1", 32'(pready0), 32'h0);
        psel = 1'b0; penable = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pready0 !== 1'b0) seen++;
        end
        chk("abort_no_ready", 32'(seen), 32'h0);
        @(posedge clk); #1;
        xfer(0, 8'h08, 1'b0, 32'h0, rd, er, ac);
        chk("abort_reread", rd, 32'h0);
        chk("abort_reread_cycle", 32'(ac), 32'd3);

        // Reset during access cycle 2 of a write to 0x10.
        @(posedge clk); #1;
        tgt = 0; psel = 1'b1; penable = 1'b0; paddr = 8'h10; pwrite = 1'b1; pwdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_pready",  32'(pready0),  32'h0);
        chk("midrst_pslverr", 32'(pslverr0), 32'h0);
        chk("midrst_prdata",  prdata0,       32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        model_reset();
        @(posedge clk); #1;
        xfer(0, 8'h10, 1'b0, 32'h0, rd, er, ac);
        chk("midrst_reread", rd, 32'h0);
        xfer(0, 8'h0C, 1'b0, 32'h0, rd, er, ac);
        chk("rst_clears_regs", rd, 32'h0);

        for (int n = 0; n < 200; n++) begin
            t  = int'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 79));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            exp = model_xfer(t, a, w, wd);
            xfer(t, a, w, wd, rd, er, ac);
            chk($sformatf("rnd%0d_ready_cycle", n), 32'(ac), (t == 1) ? 32'd1 : 32'd3);
            chk($sformatf("rnd%0d_pslverr", n), 32'(er), 32'(exp[32]));
            if (!w) chk($sformatf("rnd%0d_prdata a=%h", n, a), rd, exp[31:0]);
            if ($urandom_range(0, 1) != 0) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
